// File: rtl/br_resolve.sv
// br_resolve - branch resolution unit for the 2-bit branch predictor.
//
// Queues each prediction issued at fetch ({take, tgt, fall}) in a circular
// FIFO, checks the oldest entry against the outcome from execute, drives the
// predictor training strobe and raises a one-cycle flush with the redirect PC
// on a misprediction. All outputs are registered (resolve in N -> outputs N+1).
//
// Optional feature: define BR_RESOLVE_STATS_EN to build the saturating
// resolved-branch / misprediction counters; otherwise br_cnt/mis_cnt are 0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pred_vld/take/tgt/fall, pred_rdy   prediction push interface
//   res_vld, res_taken  actual outcome of the oldest outstanding branch
//   upd_vld, upd_taken  predictor training strobe and direction
//   flush, redirect_pc  mispredict pulse and correct PC
//   res_err             sticky: resolve seen with an empty queue
//   br_cnt, mis_cnt     statistics counters
module br_resolve #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pred_vld,
  input  logic            pred_take,
  input  logic [PC_W-1:0] pred_tgt,
  input  logic [PC_W-1:0] pred_fall,
  output logic            pred_rdy,
  input  logic            res_vld,
  input  logic            res_taken,
  output logic            upd_vld,
  output logic            upd_taken,
  output logic            flush,
  output logic [PC_W-1:0] redirect_pc,
  output logic            res_err,
  output logic [15:0]     br_cnt,
  output logic [15:0]     mis_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t state_reg, state_next;

  logic            take_mem [DEPTH];
  logic [PC_W-1:0] tgt_mem  [DEPTH];
  logic [PC_W-1:0] fall_mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;

  logic run, res_acc, pop, mispred, push;

  assign run      = (state_reg == RUN);
  assign pred_rdy = (count_reg != FULL) & run;
  assign res_acc  = res_vld & run;
  assign pop      = res_acc & (count_reg != '0);
  assign mispred  = pop & (res_taken != take_mem[rd_ptr_reg]);
  // Anything pushed alongside a mispredict is on the wrong path.
  assign push     = pred_vld & pred_rdy & ~mispred;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= RUN;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (mispred) state_next = FLUSH;
      FLUSH:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Payload storage carries no reset; validity is tracked by count_reg.
  always_ff @(posedge clk) begin
    if (push) begin
      take_mem[wr_ptr_reg] <= pred_take;
      tgt_mem[wr_ptr_reg]  <= pred_tgt;
      fall_mem[wr_ptr_reg] <= pred_fall;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (mispred) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_vld     <= 1'b0;
      upd_taken   <= 1'b0;
      flush       <= 1'b0;
      redirect_pc <= '0;
      res_err     <= 1'b0;
    end else begin
      upd_vld <= pop;
      flush   <= mispred;
      if (pop)     upd_taken   <= res_taken;
      if (mispred) redirect_pc <= res_taken ? tgt_mem[rd_ptr_reg] : fall_mem[rd_ptr_reg];
      if (res_acc && (count_reg == '0)) res_err <= 1'b1;
    end
  end

`ifdef BR_RESOLVE_STATS_EN
  logic [15:0] br_cnt_reg, mis_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_reg  <= '0;
      mis_cnt_reg <= '0;
    end else begin
      if (pop && (br_cnt_reg != 16'hFFFF))      br_cnt_reg  <= br_cnt_reg + 16'd1;
      if (mispred && (mis_cnt_reg != 16'hFFFF)) mis_cnt_reg <= mis_cnt_reg + 16'd1;
    end
  end

  assign br_cnt  = br_cnt_reg;
  assign mis_cnt = mis_cnt_reg;
`else
  assign br_cnt  = 16'd0;
  assign mis_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_br_resolve.sv
// Scoreboard bench for br_resolve: directed stimulus pushes the hand-computed
// training/flush response into a queue; a negedge monitor pops and compares
// whenever the DUT raises upd_vld. Direct checks cover reset, pred_rdy,
// res_err and the counters.
module tb_br_resolve;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pred_vld = 1'b0, pred_take = 1'b0;
  logic [15:0] pred_tgt = '0, pred_fall = '0;
  logic        pred_rdy;
  logic        res_vld = 1'b0, res_taken = 1'b0;
  logic        upd_vld, upd_taken, flush, res_err;
  logic [15:0] redirect_pc, br_cnt, mis_cnt;

  br_resolve #(.DEPTH(4), .PC_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_vld(pred_vld), .pred_take(pred_take), .pred_tgt(pred_tgt),
    .pred_fall(pred_fall), .pred_rdy(pred_rdy),
    .res_vld(res_vld), .res_taken(res_taken),
    .upd_vld(upd_vld), .upd_taken(upd_taken), .flush(flush),
    .redirect_pc(redirect_pc), .res_err(res_err),
    .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        taken;
    logic        fl;
    logic [15:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   quiet = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every training strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (upd_vld) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: upd_vld=1 with no expected resolve");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (!quiet)
            $display("upd: taken=%0b flush=%0b redirect=%h (exp %0b %0b %h)",
                     upd_taken, flush, redirect_pc, e.taken, e.fl, e.pc);
          chk("upd_taken", upd_taken, e.taken);
          chk("flush", flush, e.fl);
          if (e.fl) chk("redirect_pc", redirect_pc, e.pc);
        end
      end else if (flush) begin
        checks++;
        failures++;
        $display("FAIL flush_alone: flush=1 without upd_vld");
      end
    end
  end

  // One cycle: present inputs, let the edge take them, sample 1 time unit later.
  task automatic step(input logic pv, input logic pt, input logic [15:0] tg,
                      input logic [15:0] fa, input logic rv, input logic rt);
    pred_vld = pv; pred_take = pt; pred_tgt = tg; pred_fall = fa;
    res_vld = rv; res_taken = rt;
    @(posedge clk);
    #1;
    pred_vld = 1'b0; res_vld = 1'b0;
  endtask

  task automatic push(input logic pt, input logic [15:0] tg, input logic [15:0] fa);
    step(1'b1, pt, tg, fa, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic rt, input logic xt, input logic xf, input logic [15:0] xpc);
    exp_t e;
    e.taken = xt; e.fl = xf; e.pc = xpc;
    exp_q.push_back(e);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, rt);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pred_rdy"}, pred_rdy, 1);
    chk({tag, "_upd_vld"}, upd_vld, 0);
    chk({tag, "_upd_taken"}, upd_taken, 0);
    chk({tag, "_flush"}, flush, 0);
    chk({tag, "_redirect"}, redirect_pc, 0);
    chk({tag, "_res_err"}, res_err, 0);
    chk({tag, "_br_cnt"}, br_cnt, 0);
    chk({tag, "_mis_cnt"}, mis_cnt, 0);
  endtask

  initial begin
`ifdef BR_RESOLVE_STATS_EN
    #5000000;
`else
    #200000;
`endif
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  logic [3:0] tk;

  initial begin
    // Reset state.
    do_reset();
    chk_reset_vals("rst");

    // Resolve on empty queue right after reset.
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
    chk("empty_res_err", res_err, 1);
    chk("empty_upd_vld", upd_vld, 0);
    repeat (3) idle();
    chk("res_err_sticky", res_err, 1);
    do_reset();
    chk("res_err_cleared", res_err, 0);

    // Fill four entries; a fifth is refused.
    tk = 4'b1101; // take order 1,0,1,1 from bit 0 upward
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill_rdy%0d", i), pred_rdy, 1);
      push(tk[i], 16'h0010 + 16'(i), 16'h0020 + 16'(i));
    end
    chk("full_rdy", pred_rdy, 0);
    push(1'b0, 16'h0099, 16'h0098);
    chk("full_rdy_hold", pred_rdy, 0);
    for (int i = 0; i < 4; i++) resolve(tk[i], tk[i], 1'b0, 16'h0);
    chk("drain_rdy", pred_rdy, 1);
    chk("drain_no_err", res_err, 0);
`ifdef BR_RESOLVE_STATS_EN
    chk("br_cnt4", br_cnt, 4);
    chk("mis_cnt0", mis_cnt, 0);
`else
    chk("br_cnt_tied", br_cnt, 0);
    chk("mis_cnt_tied", mis_cnt, 0);
`endif
    // Only four were stored, so the queue is empty now.
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("fifth_not_stored", res_err, 1);
    do_reset();

    // Mispredict: predicted not-taken, actually taken -> redirect to target.
    push(1'b0, 16'h0100, 16'h0004);
    resolve(1'b1, 1'b1, 1'b1, 16'h0100);
    chk("flush_cycle_rdy", pred_rdy, 0);
    // Push and resolve during FLUSH are both ignored.
    step(1'b1, 1'b1, 16'h0777, 16'h0778, 1'b1, 1'b1);
    chk("after_flush_rdy", pred_rdy, 1);
    chk("after_flush_pulse", flush, 0);
    chk("redirect_hold", redirect_pc, 16'h0100);
    chk("flush_res_ignored", res_err, 0);
`ifdef BR_RESOLVE_STATS_EN
    chk("mis_cnt1", mis_cnt, 1);
`endif
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
    chk("flush_push_dropped", res_err, 1);
    do_reset();

    // Three queued, first mispredicts with a push in the same cycle.
    for (int i = 0; i < 3; i++) push(1'b0, 16'h0200 + 16'(i), 16'h0300 + 16'(i));
    begin
      exp_t e;
      e.taken = 1'b1; e.fl = 1'b1; e.pc = 16'h0200;
      exp_q.push_back(e);
    end
    step(1'b1, 1'b1, 16'h0500, 16'h0501, 1'b1, 1'b1);
    idle();
    chk("flushq_rdy", pred_rdy, 1);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("flushq_empty_err", res_err, 1);
    do_reset();

    // Push + resolve with count 0: resolve errors, push is kept.
    step(1'b1, 1'b1, 16'h0055, 16'h0066, 1'b1, 1'b1);
    chk("zero_push_err", res_err, 1);
    // Push + correct resolve with count 1: both happen.
    begin
      exp_t e;
      e.taken = 1'b1; e.fl = 1'b0; e.pc = 16'h0;
      exp_q.push_back(e);
    end
    step(1'b1, 1'b0, 16'h0077, 16'h0088, 1'b1, 1'b1);
    resolve(1'b0, 1'b0, 1'b0, 16'h0);
    // Mispredict the other way: predicted taken, actually not -> fall-through.
    push(1'b1, 16'h0333, 16'h0444);
    resolve(1'b0, 1'b0, 1'b1, 16'h0444);
    idle();
    chk("fall_redirect_hold", redirect_pc, 16'h0444);
    chk("fall_rdy", pred_rdy, 1);
    do_reset();

`ifdef BR_RESOLVE_STATS_EN
    // Saturation: 65537 mispredicts.
    quiet = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      push(1'b0, 16'h0123, 16'h0124);
      resolve(1'b1, 1'b1, 1'b1, 16'h0123);
      idle();
    end
    quiet = 1'b0;
    chk("mis_cnt_sat", mis_cnt, 16'hFFFF);
    chk("br_cnt_sat", br_cnt, 16'hFFFF);
`endif

    // Mid-operation asynchronous reset with two entries queued.
    push(1'b0, 16'h0abc, 16'h0abd);
    resolve(1'b1, 1'b1, 1'b1, 16'h0abc);
    idle();
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    push(1'b1, 16'h0601, 16'h0602);
    push(1'b0, 16'h0603, 16'h0604);
    chk("pre_rst_err", res_err, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
    chk("post_rst_empty", res_err, 1);
    repeat (3) idle();

    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
